// File: rtl/uart_fifo_tx_if.sv
// FIFO read-side and serial-line signals of the UART transmitter, grouped as one bundle.
// The master drives the FIFO side, and the slave is the transmitter itself.
interface uart_fifo_tx_if #(
  parameter int DBIT = 8
);
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_data;
  logic            fifo_rd;
  logic            tx;
  logic            tx_busy;
  logic            tx_done;

  modport master (
    output fifo_empty, fifo_data,
    input  fifo_rd, tx, tx_busy, tx_done
  );

  modport slave (
    input  fifo_empty, fifo_data,
    output fifo_rd, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter that drains a word FIFO: start, DBIT data bits LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_fifo_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_fifo_tx_if.slave bus
);

  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [N_W-1:0]    N_LAST   = N_W'(DBIT - 1);
  localparam logic [4:0]        S_BIT    = 5'd15;
  localparam logic [4:0]        S_STOP   = 5'(SB_TICK - 1);
  localparam logic [DVSR_W-1:0] CNT_LAST = DVSR_W'(DVSR - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic [4:0]        s_q, s_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic              tx_q, tx_d;
  logic              tick;
  logic              rd_c;
  logic              done_c;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // The divider idles at zero so the first tick lands exactly DVSR clocks into the frame.
  assign tick = (state_q != IDLE) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = 1'b1;
    rd_c    = 1'b0;
    done_c  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!bus.fifo_empty) begin
          rd_c    = 1'b1;
          b_d     = bus.fifo_data;
          s_d     = '0;
          n_d     = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^bus.fifo_data;
`endif
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PAR;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PAR: begin
        tx_d = par_q;
        if (tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (s_q == S_STOP) begin
            done_c  = 1'b1;
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Strobes are masked during reset so an aborted frame never pops or reports completion.
  assign bus.fifo_rd = rd_c & ~reset;
  assign bus.tx_done = done_c & ~reset;
  assign bus.tx_busy = (state_q != IDLE);
  assign bus.tx      = tx_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench for uart_fifo_tx: a FIFO model feeds words, and a line-level UART receiver decodes tx.
// Frame timing, pop spacing and FIFO protocol are checked by the same negedge monitor.
module tb_uart_fifo_tx;
  localparam int DBIT = 8;
  localparam int DVSR = 4;
  localparam int BIT  = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DBIT + 3;
`else
  localparam int NBITS = DBIT + 2;
`endif
  localparam int FRAME = NBITS * BIT;

  logic clk = 1'b0;
  logic reset;
  uart_fifo_tx_if #(.DBIT(DBIT)) bus ();

  uart_fifo_tx #(.DBIT(DBIT), .SB_TICK(16), .DVSR(DVSR), .DVSR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DBIT-1:0] fifo_m[$];
  logic [DBIT-1:0] exp_q[$];
  logic            empty_force = 1'b0;
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = (fifo_m.size() == 0) || empty_force;
    if (fifo_m.size() != 0) bus.fifo_data = fifo_m[0];
    else                    bus.fifo_data = '0;
  endtask

  task automatic push_word(input logic [DBIT-1:0] w);
    fifo_m.push_back(w);
    exp_q.push_back(w);
    $display("push word 0x%02h", w);
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: pop on the sampled strobe, update its outputs safely after the edge.
  always @(posedge clk) begin
    if (bus.fifo_rd === 1'b1 && fifo_m.size() != 0) void'(fifo_m.pop_front());
    #1;
    refresh();
  end

  // Monitor / receiver state
  int              cyc = 0;
  int              last_pop = 0;
  int              last_done = -100;
  int              pops = 0;
  bit              pop_valid = 0;
  bit              chk_next = 0;
  bit              rx_active = 0;
  int              rx_cnt = 0;
  logic [DBIT-1:0] rx_word;
  logic [DBIT-1:0] w_exp;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      rx_active = 0;
      pop_valid = 0;
      chk_next  = 0;
    end else begin
      if (chk_next) begin
        chk(bus.fifo_rd == !bus.fifo_empty, "pop_after_done", int'(bus.fifo_rd), int'(!bus.fifo_empty));
        chk_next = 0;
      end
      if (bus.fifo_rd) begin
        chk(!bus.fifo_empty, "rd_while_empty", int'(bus.fifo_empty), 0);
        chk(!bus.tx_busy, "rd_while_busy", int'(bus.tx_busy), 0);
        if (pop_valid && last_done == cyc - 1)
          chk(cyc - last_pop == FRAME + 1, "pop_spacing", cyc - last_pop, FRAME + 1);
        last_pop  = cyc;
        pop_valid = 1;
        pops++;
      end
      if (bus.tx_done) begin
        chk(pop_valid && (cyc - last_pop == FRAME), "done_time", cyc - last_pop, FRAME);
        last_done = cyc;
        chk_next  = 1;
      end
      if (!rx_active) begin
        if (bus.tx == 1'b0) begin
          rx_active = 1;
          rx_cnt    = 0;
          rx_word   = '0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % BIT == BIT / 2) begin
          int k;
          k = rx_cnt / BIT;
          if (k == 0) begin
            chk(bus.tx == 1'b0, "start_bit", int'(bus.tx), 0);
          end else if (k <= DBIT) begin
            rx_word[k-1] = bus.tx;
`ifdef UART_TX_PARITY_EN
          end else if (k == DBIT + 1) begin
            chk(bus.tx == ^rx_word, "parity_bit", int'(bus.tx), int'(^rx_word));
`endif
          end else begin
            chk(bus.tx == 1'b1, "stop_bit", int'(bus.tx), 1);
            rx_active = 0;
            if (exp_q.size() == 0) begin
              chk(0, "unexpected_frame", int'(rx_word), -1);
            end else begin
              w_exp = exp_q.pop_front();
              chk(rx_word == w_exp, "rx_word", int'(rx_word), int'(w_exp));
              $display("frame rx 0x%02h exp 0x%02h", rx_word, w_exp);
            end
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && fifo_m.size() == 0 && !bus.tx_busy && !rx_active) break;
      step();
    end
    chk(i < budget, name, i, budget);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    refresh();
    repeat (3) step();
    chk({bus.tx, bus.fifo_rd, bus.tx_busy, bus.tx_done} == 4'b1000, "reset_state",
        int'({bus.tx, bus.fifo_rd, bus.tx_busy, bus.tx_done}), 8);
    reset = 1'b0;

    // Idle with an empty FIFO: the line must stay quiet.
    for (int i = 0; i < 200; i++) begin
      step();
      chk({bus.tx, bus.fifo_rd, bus.tx_busy, bus.tx_done} == 4'b1000, "idle_quiet",
          int'({bus.tx, bus.fifo_rd, bus.tx_busy, bus.tx_done}), 8);
    end

    push_word(8'hA5);
    wait_drain(FRAME + 200, "drain_single");

    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h55);
    wait_drain(4 * FRAME, "drain_b2b");

`ifdef UART_TX_PARITY_EN
    push_word(8'h07);
    push_word(8'h03);
    wait_drain(3 * FRAME, "drain_parity");
`endif

    // Reset during data bit 3 of 0x3C; the next word must follow whole.
    p0 = pops;
    push_word(8'h3C);
    push_word(8'h81);
    for (int i = 0; i < 50 && pops == p0; i++) step();
    chk(pops != p0, "pop_3c", pops - p0, 1);
    repeat (289) step();
    reset = 1'b1;
    void'(exp_q.pop_front());
    step();
    chk(bus.tx == 1'b1, "reset_tx", int'(bus.tx), 1);
    chk(bus.tx_busy == 1'b0, "reset_busy", int'(bus.tx_busy), 0);
    reset = 1'b0;
    #1;
    chk(bus.fifo_rd == 1'b1, "pop_after_reset", int'(bus.fifo_rd), 1);
    wait_drain(2 * FRAME, "drain_reset");

    // fifo_empty toggling every clock while the transmitter is busy.
    push_word(8'hC3);
    push_word(8'h1E);
    push_word(8'h99);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (exp_q.size() == 0 && fifo_m.size() == 0 && !bus.tx_busy) break;
      empty_force = ~empty_force;
      refresh();
      step();
    end
    empty_force = 1'b0;
    refresh();
    wait_drain(2 * FRAME, "drain_toggle");

    // Random words with random gaps, some arriving while a frame is in flight.
    for (int i = 0; i < 12; i++) begin
      push_word(DBIT'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 900)) step();
    end
    wait_drain(14 * FRAME, "drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
